pong_match_ctrl: RTL and testbench

//   Match sequencer for the pong top level. Consumes paddle/wall collision flags and serve buttons,

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_frame_timer.sv | 33 +++
 rtl/pong_match_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the pong match controller: FSM states, ball step values
// and the bundle of edge-detected player/collision inputs.
package pong_pkg;

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_RALLY = 2'd1;
  localparam logic [1:0] ST_POINT = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [1:0] VX_LEFT  = 2'b11;
  localparam logic [1:0] VX_STOP  = 2'b00;
  localparam logic [1:0] VX_RIGHT = 2'b01;

  // Screen rows grow downwards, so "up" is the negative step.
  localparam logic [2:0] VY_UP = 3'b111;
  localparam logic [2:0] VY_DN = 3'b001;

  typedef struct packed {
    logic p1_srv;
    logic p2_srv;
    logic p1_hit;
    logic p2_hit;
    logic wall_v;
    logic wall_h;
  } pong_events_t;

  function automatic logic [2:0] negate_vy(input logic [2:0] vy);
    return 3'd0 - vy;
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// 8-bit frame counter: load wins over decrement, decrements once per frame tick
// and parks at zero.
module pong_frame_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       tick_i,
  output logic       zero_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 8'd0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: turns collision flags and serve buttons into ball velocity,
// scores, serve side and beep requests while walking SERVE->RALLY->POINT->OVER.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int POINT_FRAMES = 60,
  parameter int BEEP_FRAMES  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick_i,
  input  logic       p1_srv_i,
  input  logic       p2_srv_i,
  input  logic       p1_hit_i,
  input  logic       p2_hit_i,
  input  logic       wall_v_i,
  input  logic       wall_h_i,
  output logic [1:0] ball_vx_o,
  output logic [2:0] ball_vy_o,
  output logic       ball_load_o,
  output logic       ball_load_side_o,
  output logic       serve_side_o,
  output logic [3:0] score1_o,
  output logic [3:0] score2_o,
  output logic       beep_lo_o,
  output logic       beep_hi_o,
  output logic       game_over_o,
  output logic       winner_o
);

  localparam logic [7:0] POINT_LOAD = 8'(POINT_FRAMES);
  localparam logic [7:0] BEEP_LOAD  = 8'(BEEP_FRAMES);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  pong_events_t in_now, in_d_q, rise;

  logic [1:0] state_q, state_d;
  logic [1:0] vx_q, vx_d;
  logic [2:0] vy_q, vy_d;
  logic       serve_side_q, serve_side_d;
  logic       load_side_q, load_side_d;
  logic       load_q, load_d;
  logic [3:0] score1_q, score1_d, score2_q, score2_d;
  logic       beep_lo_q, beep_lo_d, beep_hi_q, beep_hi_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;

  logic point_load, point_zero, beep_load, beep_zero;
  logic lo_req, hi_req, scorer;

  assign in_now = {p1_srv_i, p2_srv_i, p1_hit_i, p2_hit_i, wall_v_i, wall_h_i};
  assign rise   = in_now & ~in_d_q;

  // Match FSM; the beep arbitration at the bottom consumes its lo/hi requests.
  always_comb begin
    state_d      = state_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    serve_side_d = serve_side_q;
    load_side_d  = load_side_q;
    load_d       = 1'b0;
    score1_d     = score1_q;
    score2_d     = score2_q;
    beep_lo_d    = beep_lo_q;
    beep_hi_d    = beep_hi_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    point_load   = 1'b0;
    beep_load    = 1'b0;
    lo_req       = 1'b0;
    hi_req       = 1'b0;
    scorer       = (vx_q == VX_LEFT);

    case (state_q)
      ST_SERVE: begin
        vx_d = VX_STOP;
        if (serve_side_q ? rise.p2_srv : rise.p1_srv) begin
          state_d = ST_RALLY;
          vx_d    = serve_side_q ? VX_LEFT : VX_RIGHT;
        end
      end
      ST_RALLY: begin
        if (rise.wall_v) begin
          vy_d   = negate_vy(vy_q);
          lo_req = 1'b1;
        end
        // A ball crossing the goal line beats any paddle hit in the same cycle.
        if (rise.wall_h) begin
          if (scorer) score2_d = score2_q + 4'd1;
          else        score1_d = score1_q + 4'd1;
          vx_d         = VX_STOP;
          load_d       = 1'b1;
          load_side_d  = scorer;
          serve_side_d = scorer;
          hi_req       = 1'b1;
          point_load   = 1'b1;
          state_d      = ST_POINT;
        end else if (rise.p1_hit) begin
          vx_d   = VX_RIGHT;
          lo_req = 1'b1;
        end else if (rise.p2_hit) begin
          vx_d   = VX_LEFT;
          lo_req = 1'b1;
        end
      end
      ST_POINT: begin
        if (point_zero) begin
          if ((serve_side_q ? score2_q : score1_q) == WIN) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
            winner_d    = serve_side_q;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      default: begin
        vx_d = VX_STOP;
        if (rise.p1_srv || rise.p2_srv) begin
          score1_d     = 4'd0;
          score2_d     = 4'd0;
          serve_side_d = 1'b1;
          load_d       = 1'b1;
          load_side_d  = 1'b1;
          game_over_d  = 1'b0;
          state_d      = ST_SERVE;
        end
      end
    endcase

    if (hi_req) begin
      beep_hi_d = 1'b1;
      beep_lo_d = 1'b0;
      beep_load = 1'b1;
    end else if (lo_req && !beep_hi_q) begin
      beep_lo_d = 1'b1;
      beep_load = 1'b1;
    end else if (beep_zero) begin
      beep_lo_d = 1'b0;
      beep_hi_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_d_q       <= '1;
      state_q      <= ST_SERVE;
      vx_q         <= VX_STOP;
      vy_q         <= VY_DN;
      serve_side_q <= 1'b1;
      load_side_q  <= 1'b1;
      load_q       <= 1'b0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      beep_lo_q    <= 1'b0;
      beep_hi_q    <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      in_d_q       <= in_now;
      state_q      <= state_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      serve_side_q <= serve_side_d;
      load_side_q  <= load_side_d;
      load_q       <= load_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      beep_lo_q    <= beep_lo_d;
      beep_hi_q    <= beep_hi_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  pong_frame_timer u_point_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (point_load),
    .load_val_i (POINT_LOAD),
    .tick_i     (frame_tick_i),
    .zero_o     (point_zero)
  );

  pong_frame_timer u_beep_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (beep_load),
    .load_val_i (BEEP_LOAD),
    .tick_i     (frame_tick_i),
    .zero_o     (beep_zero)
  );

  assign ball_vx_o        = vx_q;
  assign ball_vy_o        = vy_q;
  assign ball_load_o      = load_q;
  assign ball_load_side_o = load_side_q;
  assign serve_side_o     = serve_side_q;
  assign score1_o         = score1_q;
  assign score2_o         = score2_q;
  assign beep_lo_o        = beep_lo_q;
  assign beep_hi_o        = beep_hi_q;
  assign game_over_o      = game_over_q;
  assign winner_o         = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a rule-level match model.
module tb_pong_match_ctrl;

  localparam int WIN = 9;
  localparam int PF  = 2;
  localparam int BF  = 6;

  localparam logic [5:0] B_P1S = 6'b100000;
  localparam logic [5:0] B_P2S = 6'b010000;
  localparam logic [5:0] B_P1H = 6'b001000;
  localparam logic [5:0] B_P2H = 6'b000100;
  localparam logic [5:0] B_WV  = 6'b000010;
  localparam logic [5:0] B_WH  = 6'b000001;

  localparam int PH_SERVE = 0, PH_RALLY = 1, PH_POINT = 2, PH_OVER = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic p1_srv = 1'b0, p2_srv = 1'b0, p1_hit = 1'b0, p2_hit = 1'b0, wall_v = 1'b0, wall_h = 1'b0;
  logic [1:0] ball_vx;
  logic [2:0] ball_vy;
  logic ball_load, ball_load_side, serve_side;
  logic [3:0] score1, score2;
  logic beep_lo, beep_hi, game_over, winner;

  int checks = 0;
  int errors = 0;

  // Rule-level model of the match.
  int m_phase, m_vx, m_vy, m_s1, m_s2, m_pt, m_beep, m_brem;
  bit m_srv_side, m_load, m_load_side, m_over, m_winner;
  bit [5:0] m_prev;

  always #5 clk = ~clk;

  pong_match_ctrl #(.WIN_SCORE(WIN), .POINT_FRAMES(PF), .BEEP_FRAMES(BF)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_tick_i     (frame_tick),
    .p1_srv_i         (p1_srv),
    .p2_srv_i         (p2_srv),
    .p1_hit_i         (p1_hit),
    .p2_hit_i         (p2_hit),
    .wall_v_i         (wall_v),
    .wall_h_i         (wall_h),
    .ball_vx_o        (ball_vx),
    .ball_vy_o        (ball_vy),
    .ball_load_o      (ball_load),
    .ball_load_side_o (ball_load_side),
    .serve_side_o     (serve_side),
    .score1_o         (score1),
    .score2_o         (score2),
    .beep_lo_o        (beep_lo),
    .beep_hi_o        (beep_hi),
    .game_over_o      (game_over),
    .winner_o         (winner)
  );

  task automatic model_reset();
    m_phase = PH_SERVE; m_vx = 0; m_vy = 1; m_s1 = 0; m_s2 = 0; m_pt = 0;
    m_beep = 0; m_brem = 0; m_srv_side = 1; m_load = 0; m_load_side = 1;
    m_over = 0; m_winner = 0; m_prev = '1;
  endtask

  task automatic model_step();
    bit [5:0] cur, r;
    bit lo, hi, sc;
    cur = {p1_srv, p2_srv, p1_hit, p2_hit, wall_v, wall_h};
    r = cur & ~m_prev;
    m_prev = cur;
    m_load = 0; lo = 0; hi = 0;
    if (m_phase == PH_SERVE) begin
      if (m_srv_side ? r[4] : r[5]) begin
        m_phase = PH_RALLY;
        m_vx = m_srv_side ? -1 : 1;
      end
    end else if (m_phase == PH_RALLY) begin
      if (r[1]) begin m_vy = -m_vy; lo = 1; end
      if (r[0]) begin
        sc = (m_vx < 0);
        if (sc) m_s2++; else m_s1++;
        m_vx = 0; m_load = 1; m_load_side = sc; m_srv_side = sc;
        hi = 1; m_pt = PF; m_phase = PH_POINT;
      end else if (r[3]) begin m_vx = 1; lo = 1; end
      else if (r[2]) begin m_vx = -1; lo = 1; end
    end else if (m_phase == PH_POINT) begin
      if (m_pt == 0) begin
        if ((m_srv_side ? m_s2 : m_s1) == WIN) begin
          m_phase = PH_OVER; m_over = 1; m_winner = m_srv_side;
        end else m_phase = PH_SERVE;
      end else if (frame_tick) m_pt--;
    end else begin
      if (r[5] || r[4]) begin
        m_s1 = 0; m_s2 = 0; m_srv_side = 1; m_load = 1; m_load_side = 1;
        m_over = 0; m_phase = PH_SERVE;
      end
    end
    if (hi) begin m_beep = 2; m_brem = BF; end
    else if (lo && m_beep != 2) begin m_beep = 1; m_brem = BF; end
    else if (m_brem == 0) m_beep = 0;
    else if (frame_tick) m_brem--;
  endtask

  // Apply levels at the falling edge, let the rising edge act, return at the next falling edge.
  task automatic drive(input logic [5:0] lv, input logic tk);
    {p1_srv, p2_srv, p1_hit, p2_hit, wall_v, wall_h} = lv;
    frame_tick = tk;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    {p1_srv, p2_srv, p1_hit, p2_hit, wall_v, wall_h} = 6'b0;
    frame_tick = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_point();
    repeat (PF) begin
      drive(6'b0, 1'b1);
      drive(6'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    logic [19:0] got, exp;
    p2_srv = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {ball_vx, ball_vy, ball_load, ball_load_side, serve_side, score1, score2,
           beep_lo, beep_hi, game_over, winner};
    exp = {2'b00, 3'b001, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0000};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL reset_values got %h exp %h", got, exp); end
    rst_n = 1'b1;
    model_reset();
    repeat (3) drive(B_P2S, 1'b0);
    checks++;
    if (ball_vx !== 2'b00) begin errors++; $display("[TB] FAIL held_srv_no_event got %b exp 00", ball_vx); end
    drive(6'b0, 1'b0);
    drive(B_P2S, 1'b0);
    checks++;
    if (ball_vx !== 2'b11) begin errors++; $display("[TB] FAIL press_after_release got %b exp 11", ball_vx); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ball_vx, serve_side} !== 3'b001) begin
      errors++; $display("[TB] FAIL async_reset got %b exp 001", {ball_vx, serve_side});
    end
    do_reset();
  endtask

  task automatic test_serve();
    drive(B_P1S, 1'b0);
    checks++;
    if (ball_vx !== 2'b00) begin errors++; $display("[TB] FAIL nonserver_ignored got %b exp 00", ball_vx); end
    drive(6'b0, 1'b0);
    drive(B_P2S, 1'b0);
    checks++;
    if ({ball_vx, ball_load} !== 3'b110) begin
      errors++; $display("[TB] FAIL serve_p2 got %b exp 110", {ball_vx, ball_load});
    end
    drive(6'b0, 1'b0);
  endtask

  task automatic test_rally();
    drive(B_P1H, 1'b0);
    checks++;
    if ({ball_vx, beep_lo, beep_hi} !== 4'b0110) begin
      errors++; $display("[TB] FAIL p1_hit got %b exp 0110", {ball_vx, beep_lo, beep_hi});
    end
    drive(6'b0, 1'b0);
    repeat (BF - 1) begin drive(6'b0, 1'b1); drive(6'b0, 1'b0); end
    checks++;
    if (beep_lo !== 1'b1) begin errors++; $display("[TB] FAIL beep_lo_held got %b exp 1", beep_lo); end
    drive(6'b0, 1'b1);
    drive(6'b0, 1'b0);
    checks++;
    if (beep_lo !== 1'b0) begin errors++; $display("[TB] FAIL beep_lo_end got %b exp 0", beep_lo); end
    drive(B_WV, 1'b0);
    checks++;
    if ({ball_vy, beep_lo, ball_vx} !== 6'b111101) begin
      errors++; $display("[TB] FAIL wall_v got %b exp 111101", {ball_vy, beep_lo, ball_vx});
    end
    drive(6'b0, 1'b0);
  endtask

  task automatic test_point();
    drive(B_WH | B_P2H, 1'b0);
    checks++;
    if ({score1, score2, ball_vx, ball_load, ball_load_side, serve_side, beep_hi, beep_lo} !==
        {4'd1, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL point_p1 got s1=%0d s2=%0d vx=%b ld=%b lds=%b ss=%b hi=%b lo=%b exp 1 0 00 1 0 0 1 0",
               score1, score2, ball_vx, ball_load, ball_load_side, serve_side, beep_hi, beep_lo);
    end
    drive(6'b0, 1'b0);
    checks++;
    if (ball_load !== 1'b0) begin errors++; $display("[TB] FAIL load_pulse got %b exp 0", ball_load); end
    drive(B_P1S, 1'b0);
    drive(6'b0, 1'b1);
    checks++;
    if (ball_vx !== 2'b00) begin errors++; $display("[TB] FAIL point_ignores_srv got %b exp 00", ball_vx); end
    drive(6'b0, 1'b0);
    drive(6'b0, 1'b1);
    drive(6'b0, 1'b0);
    drive(B_P1S, 1'b0);
    checks++;
    if (ball_vx !== 2'b01) begin errors++; $display("[TB] FAIL serve_p1 got %b exp 01", ball_vx); end
    drive(6'b0, 1'b0);
  endtask

  task automatic test_over();
    for (int k = 1; k <= WIN; k++) begin
      drive(B_P2H, 1'b0); drive(6'b0, 1'b0);
      drive(B_WH, 1'b0); drive(6'b0, 1'b0);
      if (k == WIN - 1) begin
        checks++;
        if ({score2, game_over} !== {4'd8, 1'b0}) begin
          errors++; $display("[TB] FAIL score2_eight got %0d/%b exp 8/0", score2, game_over);
        end
      end
      wait_point();
      if (k < WIN) begin drive(B_P2S, 1'b0); drive(6'b0, 1'b0); end
    end
    checks++;
    if ({game_over, winner, score2, ball_vx} !== {1'b1, 1'b1, 4'd9, 2'b00}) begin
      errors++; $display("[TB] FAIL match_over got go=%b w=%b s2=%0d vx=%b exp 1 1 9 00",
                         game_over, winner, score2, ball_vx);
    end
    drive(B_P1S, 1'b0);
    checks++;
    if ({score1, score2, game_over, ball_load, ball_load_side, serve_side} !== {8'd0, 4'b0111}) begin
      errors++; $display("[TB] FAIL restart got s1=%0d s2=%0d go=%b ld=%b lds=%b ss=%b exp 0 0 0 1 1 1",
                         score1, score2, game_over, ball_load, ball_load_side, serve_side);
    end
    drive(6'b0, 1'b0);
    drive(B_P2S, 1'b0);
    checks++;
    if (ball_vx !== 2'b11) begin errors++; $display("[TB] FAIL serve_after_over got %b exp 11", ball_vx); end
    drive(6'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] lv;
    logic [19:0] got, exp;
    do_reset();
    lv = 6'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0)  lv[5] = ~lv[5];
      if ($urandom_range(0, 5) == 0)  lv[4] = ~lv[4];
      if ($urandom_range(0, 4) == 0)  lv[3] = ~lv[3];
      if ($urandom_range(0, 4) == 0)  lv[2] = ~lv[2];
      if ($urandom_range(0, 7) == 0)  lv[1] = ~lv[1];
      if ($urandom_range(0, 11) == 0) lv[0] = ~lv[0];
      drive(lv, ($urandom_range(0, 2) == 0));
      got = {ball_vx, ball_vy, ball_load, ball_load_side, serve_side, score1, score2,
             beep_lo, beep_hi, game_over, winner};
      exp = {(m_vx < 0) ? 2'b11 : (m_vx > 0) ? 2'b01 : 2'b00,
             (m_vy > 0) ? 3'b001 : 3'b111,
             m_load, m_load_side, m_srv_side, 4'(m_s1), 4'(m_s2),
             m_beep == 1, m_beep == 2, m_over, m_winner};
      checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL random_cycle%0d got %h exp %h", c, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_rally();
    test_point();
    test_over();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
